// File: rtl/serv_alu_ds.sv
// serv_alu_ds: digit-serial ALU (W bits/cycle, LSB first); optional o_ovf via SERV_ALU_OVF_EN
module serv_alu_ds #(
  parameter int W    = 1,
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [3:0]   i_op,
  input  logic         i_en,
  input  logic [W-1:0] i_rs1,
  input  logic [W-1:0] i_rs2,
  input  logic [W-1:0] i_imm,
  input  logic         i_op_b_rs2,
  output logic [W-1:0] o_rd,
  output logic         o_rd_vld,
  output logic         o_cmp,
  output logic         o_busy,
  output logic         o_done
`ifdef SERV_ALU_OVF_EN
  , output logic       o_ovf
`endif
);
  localparam int N  = XLEN / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, PASS1, PASS2} state_t;
  state_t state, state_nxt;
  logic [3:0]      op;
  logic [CW-1:0]   cnt;
  logic            carry, eq, lt;
  logic [XLEN-1:0] sbuf;
  logic [SW-1:0]   shamt;
  logic is_add, is_sub, is_slt, is_sltu, is_and, is_or, is_xor, is_eq, is_sll, is_srl, is_sra;
  logic cmp_op, two_pass, acc, last, eq_nxt, lt_nxt;
  logic [W-1:0]    b, bx, msk, ua, ub, p1_rd, p2_rd;
  logic [W:0]      sum;
  logic [XLEN-1:0] sra_v, sh, shd, bext;
  assign is_add   = op == 4'd0;
  assign is_sub   = op == 4'd1;
  assign is_slt   = op == 4'd2;
  assign is_sltu  = op == 4'd3;
  assign is_and   = op == 4'd4;
  assign is_or    = op == 4'd5;
  assign is_xor   = op == 4'd6;
  assign is_eq    = op == 4'd7;
  assign is_sll   = op == 4'd8;
  assign is_srl   = op == 4'd9;
  assign is_sra   = op == 4'd10;
  assign cmp_op   = is_slt | is_sltu;
  assign two_pass = cmp_op | is_sll | is_srl | is_sra;
  assign acc      = i_en & (state != IDLE);
  assign last     = cnt == CW'(N - 1);
  assign b        = i_op_b_rs2 ? i_rs2 : i_imm;
  assign bx       = is_sub ? ~b : b;
  // carry-in is forced high on digit 0 of a subtract to form the two's complement
  assign sum      = {1'b0, i_rs1} + {1'b0, bx} + (W+1)'(carry | (is_sub & (cnt == '0)));
  // flipping the sign bit on the top digit turns the unsigned digit compare into a signed one
  assign msk      = W'(is_slt & last) << (W - 1);
  assign ua       = i_rs1 ^ msk;
  assign ub       = b ^ msk;
  assign lt_nxt   = (ua != ub) ? (ua < ub) : lt;
  assign eq_nxt   = eq & (i_rs1 == b);
  assign sra_v    = $signed(sbuf) >>> shamt;
  assign sh       = is_sll ? sbuf << shamt : is_sra ? sra_v : sbuf >> shamt;
  assign shd      = sh >> (cnt * W);
  assign bext     = XLEN'(b) << (cnt * W);
  assign p1_rd    = is_and ? i_rs1 & b : is_or ? i_rs1 | b : is_xor ? i_rs1 ^ b : sum[W-1:0];
  assign p2_rd    = cmp_op ? ((cnt == '0) ? W'(lt) : '0) : shd[W-1:0];
  assign o_rd_vld = i_en & ((state == PASS2) |
                    ((state == PASS1) & (is_add | is_sub | is_and | is_or | is_xor)));
  assign o_rd     = o_rd_vld ? ((state == PASS2) ? p2_rd : p1_rd) : '0;
  assign o_done   = acc & last & ((state == PASS2) | ~two_pass);
  assign o_busy   = state != IDLE;
  // state register
  always_ff @(posedge clk)
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  // next state: a pass ends on its last accepted digit
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = i_start ? PASS1 : IDLE;
    else if (acc & last) state_nxt = ((state == PASS1) & two_pass) ? PASS2 : IDLE;
  end
  // datapath: counter, carry, compare flags, shift buffer and shift amount
  always_ff @(posedge clk)
    if (i_rst) begin
      op    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      eq    <= 1'b1;
      lt    <= 1'b0;
      o_cmp <= 1'b0;
      sbuf  <= '0;
      shamt <= '0;
    end else if (state == IDLE) begin
      if (i_start) begin
        op    <= (i_op > 4'd10) ? 4'd0 : i_op;
        cnt   <= '0;
        carry <= 1'b0;
        eq    <= 1'b1;
        lt    <= 1'b0;
        o_cmp <= 1'b0;
        shamt <= '0;
      end
    end else if (i_en) begin
      cnt <= last ? '0 : cnt + CW'(1);
      if (state == PASS1) begin
        carry <= last ? 1'b0 : sum[W];
        eq    <= eq_nxt;
        lt    <= lt_nxt;
        sbuf  <= (XLEN'(i_rs1) << (XLEN - W)) | (sbuf >> W);
        shamt <= shamt | bext[SW-1:0];
      end
      if (o_done) o_cmp <= is_eq ? eq_nxt : cmp_op ? lt : 1'b0;
    end
`ifdef SERV_ALU_OVF_EN
  logic c_msb;
  assign c_msb = i_rs1[W-1] ^ bx[W-1] ^ sum[W-1];
  // signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk)
    if (i_rst) o_ovf <= 1'b0;
    else if ((state == IDLE) & i_start) o_ovf <= 1'b0;
    else if (o_done) o_ovf <= (is_add | is_sub) & (c_msb ^ sum[W]);
`endif
endmodule

// File: tb/tb_serv_alu_ds.sv
// tb_serv_alu_ds: directed self-checking bench for serv_alu_ds at W=4, XLEN=32
module tb_serv_alu_ds;
  logic       clk = 1'b0;
  logic       rst, start, en, bsel;
  logic [3:0] op, rs1, rs2, imm, rd;
  logic       rd_vld, cmp, busy, done;
  int total = 0, bad = 0;
  logic [31:0] res;
`ifdef SERV_ALU_OVF_EN
  logic ovf;
`endif
  always #5 clk = ~clk;
  serv_alu_ds #(.W(4), .XLEN(32)) dut (
    .clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_en(en),
    .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .i_op_b_rs2(bsel),
    .o_rd(rd), .o_rd_vld(rd_vld), .o_cmp(cmp), .o_busy(busy), .o_done(done)
`ifdef SERV_ALU_OVF_EN
    , .o_ovf(ovf)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [3:0] o, input logic bs);
    @(negedge clk);
    op = o; bsel = bs; start = 1'b1; en = 1'b1; rs1 = 4'hF;
    @(negedge clk);
    start = 1'b0; en = 1'b0;
  endtask
  task automatic pass(input string tag, input logic [31:0] a, input logic [31:0] r2,
                      input logic [31:0] im, input bit gaps, input int poke,
                      output logic [31:0] r, output int vn, output int dn);
    int g;
    r = '0; vn = 0; dn = 0;
    for (int d = 0; d < 8; d++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      repeat (g) begin
        en = 1'b0; rs1 = 4'($urandom); rs2 = 4'($urandom); imm = 4'($urandom);
        #1 chk({tag, "_gap"}, 32'({rd_vld, rd}), 32'd0);
        @(negedge clk);
      end
      en = 1'b1;
      if (d == poke) begin start = 1'b1; op = 4'd6; end
      rs1 = a[d*4 +: 4]; rs2 = r2[d*4 +: 4]; imm = im[d*4 +: 4];
      #1;
      if (rd_vld) begin r[d*4 +: 4] = rd; vn++; end
      if (done) dn += (d == 7) ? 1 : 100;
      @(negedge clk);
      start = 1'b0;
    end
    en = 1'b0;
  endtask
  task automatic run(input string tag, input logic [3:0] o, input logic bs, input logic [31:0] a,
                     input logic [31:0] r2, input logic [31:0] im, input bit twop,
                     input bit gaps, input int poke, output logic [31:0] r);
    logic [31:0] p1;
    int v1, d1, v2, d2;
    start_op(o, bs);
    pass(tag, a, r2, im, gaps, poke, p1, v1, d1);
    if (twop) begin
      chk({tag, "_p1vld"}, 32'(v1), 32'd0);
      chk({tag, "_p1done"}, 32'(d1), 32'd0);
      chk({tag, "_midbusy"}, 32'(busy), 32'd1);
      pass(tag, $urandom, $urandom, $urandom, gaps, -1, r, v2, d2);
      chk({tag, "_p2vld"}, 32'(v2), 32'd8);
      chk({tag, "_p2done"}, 32'(d2), 32'd1);
    end else begin
      r = p1;
      chk({tag, "_done"}, 32'(d1), 32'd1);
    end
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; en = 1'b0; bsel = 1'b1; op = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", 32'({busy, done, rd_vld, rd, cmp}), 32'd0);
    rst = 1'b0;
    run("add", 4'd0, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'hDEADBEEF, 0, 0, -1, res);
    chk("add_rd", res, 32'h80000000);
`ifdef SERV_ALU_OVF_EN
    chk("add_ovf", 32'(ovf), 32'd1);
`endif
    run("sub", 4'd1, 1'b0, 32'd5, 32'h12345678, 32'd7, 0, 0, -1, res);
    chk("sub_rd", res, 32'hFFFFFFFE);
`ifdef SERV_ALU_OVF_EN
    chk("sub_ovf", 32'(ovf), 32'd0);
`endif
    run("slt", 4'd2, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, -1, res);
    chk("slt_rd", res, 32'd1);
    chk("slt_cmp", 32'(cmp), 32'd1);
    run("sltu", 4'd3, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, -1, res);
    chk("sltu_rd", res, 32'd0);
    chk("sltu_cmp", 32'(cmp), 32'd0);
    run("sra", 4'd10, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd4, 1, 0, -1, res);
    chk("sra_rd", res, 32'hF8000000);
    run("srl", 4'd9, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd4, 1, 0, -1, res);
    chk("srl_rd", res, 32'h08000000);
    run("sll31", 4'd8, 1'b0, 32'h00000001, 32'd0, 32'd31, 1, 0, -1, res);
    chk("sll31_rd", res, 32'h80000000);
    run("sll0", 4'd8, 1'b0, 32'hA5A51234, 32'd3, 32'd0, 1, 0, -1, res);
    chk("sll0_rd", res, 32'hA5A51234);
    run("eq1", 4'd7, 1'b1, 32'h12345678, 32'h12345678, 32'd0, 0, 0, -1, res);
    chk("eq1_rd", res, 32'd0);
    chk("eq1_cmp", 32'(cmp), 32'd1);
    run("eq0", 4'd7, 1'b1, 32'h12345678, 32'h12345679, 32'd0, 0, 0, -1, res);
    chk("eq0_cmp", 32'(cmp), 32'd0);
    run("and", 4'd4, 1'b1, 32'hF0F0A5A5, 32'h0FF05A5A, 32'd0, 0, 0, -1, res);
    chk("and_rd", res, 32'h00F00000);
    run("or", 4'd5, 1'b1, 32'hF0F0A5A5, 32'h0FF05A5A, 32'd0, 0, 0, -1, res);
    chk("or_rd", res, 32'hFFF0FFFF);
    run("xor", 4'd6, 1'b1, 32'hF0F0A5A5, 32'h0FF05A5A, 32'd0, 0, 0, -1, res);
    chk("xor_rd", res, 32'hFF00FFFF);
    chk("xor_cmp", 32'(cmp), 32'd0);
    run("addgap", 4'd0, 1'b1, 32'h12345678, 32'h0FEDCBA9, 32'd0, 0, 1, -1, res);
    chk("addgap_rd", res, 32'h22222221);
    run("midstart", 4'd0, 1'b1, 32'h12345678, 32'h0FEDCBA9, 32'd0, 0, 0, 3, res);
    chk("midstart_rd", res, 32'h22222221);
    run("op12", 4'd12, 1'b1, 32'd3, 32'd4, 32'd0, 0, 0, -1, res);
    chk("op12_rd", res, 32'd7);
    @(negedge clk);
    en = 1'b1; rs1 = 4'hF; rs2 = 4'hF; imm = 4'hF;
    repeat (3) begin
      #1 chk("idle_en", 32'({rd_vld, rd, busy, done}), 32'd0);
      @(negedge clk);
    end
    en = 1'b0;
    start_op(4'd10, 1'b0);
    for (int d = 0; d < 3; d++) begin
      en = 1'b1; rs1 = (d == 0) ? 4'h0 : 4'h0; imm = (d == 0) ? 4'h4 : 4'h0;
      @(negedge clk);
    end
    rst = 1'b1; en = 1'b1;
    #1 chk("rst_mid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    chk("rst_mid_busy", 32'({busy, done}), 32'd0);
    run("add11", 4'd0, 1'b1, 32'd1, 32'd1, 32'd0, 0, 0, -1, res);
    chk("add11_rd", res, 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
